bp_be_dep_tracker: RTL and testbench
====================================

# bp_be_dep_tracker

Tracks the hazard-relevant status of every instruction in flight in the backend execution pipe. Produces the per-stage dependency-status vector and the memory credit flags that the dispatch hazard detector checks each cycle. Sits between the issue/dispatch point and the hazard detector. It captures each dispatched instruction's destination and writeback class, shifts that record down the EX1→FWB stages, squashes records on a pipeline kill, and counts outstanding memory operations.

## Interface
Parameters:
- depth_p, 5: number of tracked stages (EX1, EX2, IWB, FWB, post-FWB); minimum 4
- reg_addr_width_p, 5: register address width
- credits_p, 4: maximum outstanding memory operations; minimum 1

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  reset, asynchronous assert, active-low
- dispatch_v_i  in  1  instruction enters EX1 this cycle
- dispatch_rd_addr_i  in  reg_addr_width_p  destination register
- dispatch_irf_w_i  in  1  writes the integer register file
- dispatch_frf_w_i  in  1  writes the FP register file
- dispatch_mul_i / dispatch_mem_i / dispatch_fp_i / dispatch_serial_i  in  1 each  pipe class and serializing flag
- kill_i  in  2  bit 0 squashes EX1; bit 1 squashes EX1 and EX2
- mem_resp_v_i  in  1  one memory operation retired or responded
- dep_status_o  out  depth_p*12  per stage i, LSB-first: {rd_addr[4:0], fp_fwb_v, mem_fwb_v, mem_iwb_v, mul_iwb_v, serial_v, mem_v, v}
- credits_full_o  out  1  outstanding count == credits_p
- credits_empty_o  out  1  outstanding count == 0

## Operation
- Record capture at EX1:
  - v = 1, mem_v = mem, serial_v = serial.
  - mul_iwb_v = mul & irf_w & (rd≠0); mem_iwb_v = mem & irf_w & (rd≠0).
  - mem_fwb_v = mem & frf_w; fp_fwb_v = fp & frf_w.
  - rd_addr is stored verbatim.
- Shift: every cycle stage[i+1] <= stage[i]. The last stage's record is discarded. The pipe never stalls.
- Stage 0 loads the new record if dispatch_v_i && kill_i==0; otherwise it loads all-zero.
- Kill:
  - kill_i[0] zeroes all flag bits of the record leaving stage 0.
  - kill_i[1] zeroes the records leaving stages 0 and 1.
  - rd_addr of a killed record is don't-care; the bench must not check it.
  - Any kill bit suppresses capture of a same-cycle dispatch.
- Credit counter, width clog2(credits_p+1):
  - Increments on a captured dispatch with mem=1.
  - Decrements on mem_resp_v_i.
  - Simultaneous increment and decrement leaves the count unchanged.
  - An increment at full is ignored, and a decrement at zero is ignored. Both are flagged by a simulation-only assertion.
  - A killed memory instruction still holds its credit until mem_resp_v_i. The memory unit responds to squashed requests.
- Outputs are register-driven: dep_status_o directly, credit flags as compares on the counter register. There are no combinational paths from inputs.

## Timing
- Reset (reset_n_i low, asynchronous): all stages zero, count 0. dep_status_o = 0, credits_empty_o = 1, credits_full_o = 0. Reset deasserts synchronously to clk_i.
- Reset mid-operation clears all in-flight records and credits immediately.
- Latency: a dispatch in cycle N appears in stage 0 at cycle N+1 and in stage k at cycle N+1+k. It leaves the vector at cycle N+1+depth_p.
- Credit flags reflect a dispatch or response one cycle later.
- Back-to-back dispatch every cycle is supported.

## Configuration
- BP_BE_DEP_FP_EN defined: mem_fwb_v and fp_fwb_v are tracked as above.
- BP_BE_DEP_FP_EN undefined:
  - mem_fwb_v and fp_fwb_v are tied to 0, and dispatch_frf_w_i and dispatch_fp_i are ignored.
  - The flops are removed.
  - The dep_status_o layout and width are unchanged.

## Test plan
- Reset: hold reset_n_i low mid-stream with 3 records live → dep_status_o=0 and empty=1 asynchronously, before the next edge.
- Single mem integer load (rd=7, mem=1, irf_w=1) in cycle 0 → stage0 at cycle 1 has v=1, mem_v=1, mem_iwb_v=1, rd=7. Stage 4 at cycle 5, gone at cycle 6. empty=0 from cycle 1 until mem_resp_v_i.
- rd=0 with mul=1, irf_w=1 → mul_iwb_v=0, v=1.
- Dispatch every cycle, then kill_i=2'b10 at cycle 3 → records in EX1 and EX2 arrive invalid in EX2 and IWB. The cycle-3 dispatch is not captured. Older records are untouched.
- Fill credits with 4 mem dispatches → full=1 at the cycle after the 4th. A simultaneous mem dispatch and mem_resp at full → count stays 4.
- Build without BP_BE_DEP_FP_EN; dispatch fp=1, frf_w=1 → fp_fwb_v=0 in every stage, v=1.

Source files
------------

// File: rtl/bp_be_dep_tracker.sv
// Backend dependency tracker: per-stage hazard records for EX1..post-FWB plus outstanding memory credits.
// Optional FP writeback tracking is built in when BP_BE_DEP_FP_EN is defined.
module bp_be_dep_tracker #(
    parameter int depth_p          = 5,
    parameter int reg_addr_width_p = 5,
    parameter int credits_p        = 4,
    localparam int rec_w           = reg_addr_width_p + 7,
    localparam int cnt_w           = $clog2(credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         dispatch_v_i,
    input  logic [reg_addr_width_p-1:0]  dispatch_rd_addr_i,
    input  logic                         dispatch_irf_w_i,
    input  logic                         dispatch_frf_w_i,
    input  logic                         dispatch_mul_i,
    input  logic                         dispatch_mem_i,
    input  logic                         dispatch_fp_i,
    input  logic                         dispatch_serial_i,
    input  logic [1:0]                   kill_i,
    input  logic                         mem_resp_v_i,
    output logic [depth_p*rec_w-1:0]     dep_status_o,
    output logic                         credits_full_o,
    output logic                         credits_empty_o
);

    localparam int base_w = reg_addr_width_p + 5;

    // Integer-side record: {rd_addr, mem_iwb_v, mul_iwb_v, serial_v, mem_v, v}
    logic [depth_p-1:0][base_w-1:0] base_q;
    logic [depth_p-1:0][1:0]        fp_q;
    logic [base_w-1:0]              base_new;
    logic [depth_p-1:0]             leave_kill;
    logic                           capture, rd_nz;

    assign capture  = dispatch_v_i && (kill_i == 2'b00);
    assign rd_nz    = |dispatch_rd_addr_i;
    assign base_new = {dispatch_rd_addr_i,
                       dispatch_mem_i & dispatch_irf_w_i & rd_nz,
                       dispatch_mul_i & dispatch_irf_w_i & rd_nz,
                       dispatch_serial_i, dispatch_mem_i, 1'b1};

    // leave_kill[i] squashes the record moving out of stage i
    always_comb begin
        leave_kill    = '0;
        leave_kill[0] = |kill_i;
        leave_kill[1] = kill_i[1];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            base_q <= '0;
        end else begin
            base_q[0] <= capture ? base_new : '0;
            for (int i = 1; i < depth_p; i++)
                base_q[i] <= leave_kill[i-1] ? '0 : base_q[i-1];
        end
    end

`ifdef BP_BE_DEP_FP_EN
    // FP record: {fp_fwb_v, mem_fwb_v}
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fp_q <= '0;
        end else begin
            fp_q[0] <= capture ? {dispatch_fp_i & dispatch_frf_w_i,
                                  dispatch_mem_i & dispatch_frf_w_i} : 2'b00;
            for (int i = 1; i < depth_p; i++)
                fp_q[i] <= leave_kill[i-1] ? 2'b00 : fp_q[i-1];
        end
    end
`else
    logic unused_fp;
    assign unused_fp = ^{dispatch_frf_w_i, dispatch_fp_i};
    assign fp_q      = '0;
`endif

    for (genvar g = 0; g < depth_p; g++) begin : g_stage
        assign dep_status_o[g*rec_w +: rec_w] =
            {base_q[g][base_w-1 -: reg_addr_width_p], fp_q[g], base_q[g][4:0]};
    end

    // Outstanding memory credits; killed ops keep theirs until the response returns
    logic [cnt_w-1:0] cnt_q;
    logic             inc, dec, full, empty;

    assign inc   = capture && dispatch_mem_i;
    assign dec   = mem_resp_v_i;
    assign full  = (cnt_q == cnt_w'(credits_p));
    assign empty = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            cnt_q <= '0;
        else if (inc && !dec && !full)
            cnt_q <= cnt_q + cnt_w'(1);
        else if (dec && !inc && !empty)
            cnt_q <= cnt_q - cnt_w'(1);
    end

    assign credits_full_o  = full;
    assign credits_empty_o = empty;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(inc && !dec && full)) else $error("credit overflow");
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(dec && !inc && empty)) else $error("credit underflow");
`endif

endmodule

// File: tb/tb_bp_be_dep_tracker.sv
// Directed bench for bp_be_dep_tracker: stage-0 scoreboard plus direct stage/credit checks.
module tb_bp_be_dep_tracker;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        dispatch_v_i = 1'b0;
    logic [4:0]  dispatch_rd_addr_i = '0;
    logic        dispatch_irf_w_i = 1'b0, dispatch_frf_w_i = 1'b0;
    logic        dispatch_mul_i = 1'b0, dispatch_mem_i = 1'b0;
    logic        dispatch_fp_i = 1'b0, dispatch_serial_i = 1'b0;
    logic [1:0]  kill_i = '0;
    logic        mem_resp_v_i = 1'b0;
    logic [59:0] dep_status_o;
    logic        credits_full_o, credits_empty_o;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    bp_be_dep_tracker dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .dispatch_v_i(dispatch_v_i), .dispatch_rd_addr_i(dispatch_rd_addr_i),
        .dispatch_irf_w_i(dispatch_irf_w_i), .dispatch_frf_w_i(dispatch_frf_w_i),
        .dispatch_mul_i(dispatch_mul_i), .dispatch_mem_i(dispatch_mem_i),
        .dispatch_fp_i(dispatch_fp_i), .dispatch_serial_i(dispatch_serial_i),
        .kill_i(kill_i), .mem_resp_v_i(mem_resp_v_i),
        .dep_status_o(dep_status_o),
        .credits_full_o(credits_full_o), .credits_empty_o(credits_empty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] stg(input int i);
        return dep_status_o[i*12 +: 12];
    endfunction

    task automatic chk(input string tag, input logic [59:0] obs, input logic [59:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle, push the expected stage-0 record, then compare it after the edge
    task automatic step(input logic v, input logic [4:0] rd, input logic irf, input logic frf,
                        input logic mul, input logic mem, input logic fp, input logic ser,
                        input logic [1:0] kill, input logic resp);
        logic [11:0] e, got;
        logic        nz, fpf, mff;
        nz  = (rd != 5'd0);
`ifdef BP_BE_DEP_FP_EN
        fpf = fp & frf;
        mff = mem & frf;
`else
        fpf = 1'b0;
        mff = 1'b0;
`endif
        e = (v && kill == 2'b00) ?
            {rd, fpf, mff, mem & irf & nz, mul & irf & nz, ser, mem, 1'b1} : 12'h000;
        exp_q.push_back(e);
        dispatch_v_i = v; dispatch_rd_addr_i = rd; dispatch_irf_w_i = irf;
        dispatch_frf_w_i = frf; dispatch_mul_i = mul; dispatch_mem_i = mem;
        dispatch_fp_i = fp; dispatch_serial_i = ser; kill_i = kill; mem_resp_v_i = resp;
        tick();
        dispatch_v_i = 1'b0; kill_i = 2'b00; mem_resp_v_i = 1'b0;
        got = exp_q.pop_front();
        chk("stage0", 60'(stg(0)), 60'(got));
    endtask

    task automatic idle(input logic resp);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, resp);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_dep", dep_status_o, 60'h0);
        chk("rst_empty", 60'(credits_empty_o), 60'h1);
        chk("rst_full", 60'(credits_full_o), 60'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // Single integer load rd=7: walks all five stages, holds a credit until response
        step(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("load_empty", 60'(credits_empty_o), 60'h0);
        for (int k = 1; k < 5; k++) idle(1'b0);
        chk("load_stage4", 60'(stg(4)), 60'h393);
        idle(1'b0);
        chk("load_gone", 60'(stg(4)), 60'h0);
        chk("load_empty_held", 60'(credits_empty_o), 60'h0);
        idle(1'b1);
        chk("load_empty_resp", 60'(credits_empty_o), 60'h1);

        // rd=0 suppresses mul_iwb_v; nonzero rd keeps it; serial flag
        step(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("mul_rd0", 60'(stg(0)), 60'h001);
        step(1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        chk("mul_rd5_s1", 60'(stg(1)), 60'h289);

        // Back-to-back A,B,C then kill=10 with dispatch D
        step(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        step(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        chk("kill2_s1_flags", 60'(stg(1) & 12'h07f), 60'h0);
        chk("kill2_s2_flags", 60'(stg(2) & 12'h07f), 60'h0);
        chk("kill2_s3_old", 60'(stg(3)), 60'h089);

        // E,F then kill=01: only F is squashed, E moves on untouched
        step(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        chk("kill1_s1_flags", 60'(stg(1) & 12'h07f), 60'h0);
        chk("kill1_s2_keep", 60'(stg(2)), 60'h201);

        // Fill credits with four mem dispatches
        for (int k = 0; k < 4; k++) begin
            chk("fill_not_full", 60'(credits_full_o), 60'h0);
            step(1'b1, 5'(8 + k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        end
        chk("fill_full", 60'(credits_full_o), 60'h1);
        step(1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        chk("full_inc_dec", 60'(credits_full_o), 60'h1);
        idle(1'b1);
        chk("drain_not_full", 60'(credits_full_o), 60'h0);
        idle(1'b1);
        idle(1'b1);
        chk("drain_not_empty", 60'(credits_empty_o), 60'h0);
        idle(1'b1);
        chk("drain_empty", 60'(credits_empty_o), 60'h1);

        // FP writer: fp_fwb_v follows the build configuration in every stage
        step(1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k < 5; k++) begin
            idle(1'b0);
`ifdef BP_BE_DEP_FP_EN
            chk("fp_stage", 60'(stg(k)), 60'h4c1);
`else
            chk("fp_stage", 60'(stg(k)), 60'h481);
`endif
        end

        // Async reset with three live records and one outstanding credit
        step(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("pre_rst_empty", 60'(credits_empty_o), 60'h0);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_dep", dep_status_o, 60'h0);
        chk("async_rst_empty", 60'(credits_empty_o), 60'h1);
        exp_q.delete();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
